// File: rtl/axi_read_only_ctrl_if.sv
// AXI4 read channel (AR/R) plus the single-ported memory request bundle.
// Latency: none, this is only a grouping of wires.
// Backpressure: carried by the ARVALID/ARREADY, RVALID/RREADY and valid_o/grant_i pairs.
interface axi_read_only_ctrl_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_RDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_RDATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH     = 16
);
  // AR channel
  logic [AXI4_ID_WIDTH-1:0]      ARID_i;
  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i;
  logic [7:0]                    ARLEN_i;
  logic [2:0]                    ARSIZE_i;
  logic [1:0]                    ARBURST_i;
  logic                          ARLOCK_i;
  logic [3:0]                    ARCACHE_i;
  logic [2:0]                    ARPROT_i;
  logic [3:0]                    ARREGION_i;
  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i;
  logic [3:0]                    ARQOS_i;
  logic                          ARVALID_i;
  logic                          ARREADY_o;
  // R channel
  logic [AXI4_ID_WIDTH-1:0]      RID_o;
  logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o;
  logic [1:0]                    RRESP_o;
  logic                          RLAST_o;
  logic [AXI4_USER_WIDTH-1:0]    RUSER_o;
  logic                          RVALID_o;
  logic                          RREADY_i;
  // memory port and arbiter handshake
  logic                          MEM_CEN_o;
  logic                          MEM_WEN_o;
  logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o;
  logic [AXI4_RDATA_WIDTH-1:0]   MEM_D_o;
  logic [AXI_NUMBYTES-1:0]       MEM_BE_o;
  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i;
  logic                          grant_i;
  logic                          valid_o;

  modport slave (
    input  ARID_i, ARADDR_i, ARLEN_i, ARSIZE_i, ARBURST_i, ARLOCK_i, ARCACHE_i,
           ARPROT_i, ARREGION_i, ARUSER_i, ARQOS_i, ARVALID_i, RREADY_i, MEM_Q_i, grant_i,
    output ARREADY_o, RID_o, RDATA_o, RRESP_o, RLAST_o, RUSER_o, RVALID_o,
           MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o, valid_o
  );

  modport master (
    output ARID_i, ARADDR_i, ARLEN_i, ARSIZE_i, ARBURST_i, ARLOCK_i, ARCACHE_i,
           ARPROT_i, ARREGION_i, ARUSER_i, ARQOS_i, ARVALID_i, RREADY_i, MEM_Q_i, grant_i,
    input  ARREADY_o, RID_o, RDATA_o, RRESP_o, RLAST_o, RUSER_o, RVALID_o,
           MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o, valid_o
  );
endinterface

// File: rtl/axi_read_only_ctrl.sv
// Small synchronous FIFO holding returned read beats; DEPTH must be a power of two.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: none internally; the producer must never push into a full FIFO.
module axi_read_only_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_pop;

  assign do_pop   = pop_rdy & (cnt_q != '0);
  assign head_dat = slot_q[rd_q];
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_vld) begin
        slot_q[wr_q] <= push_dat;
        wr_q         <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_vld) - (AW+1)'(do_pop);
    end
  end
endmodule

// AXI4 read slave turning AR bursts into single-word reads on an arbitrated memory port.
// Latency: AR handshake N -> memory request N+1 -> RVALID N+3; one beat per cycle unstalled.
// Backpressure: issue stops while returned+inflight beats would overflow the 2-entry R buffer.
module axi_read_only_ctrl #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_RDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_RDATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH     = 16
) (
  input logic                 clk,
  input logic                 rst,
  axi_read_only_ctrl_if.slave bus
);
  localparam int OFFS = $clog2(AXI_NUMBYTES);

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t state_q, state_d;

  logic                        ar_ready_q;
  logic                        ar_hs;
  logic [AXI4_ID_WIDTH-1:0]    id_q;
  logic [AXI4_USER_WIDTH-1:0]  user_q;
  logic [7:0]                  len_q;
  logic [1:0]                  burst_q;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q;
  logic [8:0]                  issued_q;
  logic                        inflight_q;
  logic                        inflight_last_q;

  logic                        req_vld;
  logic                        mem_acc;
  logic                        r_pop;
  logic [2:0]                  occ;

  logic [AXI4_RDATA_WIDTH:0]   head;
  logic                        fifo_empty;
  logic [1:0]                  fifo_cnt;

  // Sideband AR fields carry no meaning for a full-width single-port read.
  logic unused_ar;
  assign unused_ar = ^{bus.ARSIZE_i, bus.ARLOCK_i, bus.ARCACHE_i, bus.ARPROT_i,
                       bus.ARREGION_i, bus.ARQOS_i, bus.ARADDR_i};

  assign ar_hs   = bus.ARVALID_i & ar_ready_q;
  assign r_pop   = ~fifo_empty & bus.RREADY_i;
  assign mem_acc = req_vld & bus.grant_i;

  // A beat leaving the buffer this cycle frees its slot in time for a new request,
  // which keeps one beat per cycle flowing when RREADY stays high.
  assign occ = 3'(fifo_cnt) + 3'(inflight_q) - 3'(r_pop);

  // Next state and memory request.
  always_comb begin
    state_d = state_q;
    req_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (ar_hs) state_d = BURST;
      end
      BURST: begin
        req_vld = (issued_q <= {1'b0, len_q}) && (occ < 3'd2);
        if (r_pop && head[AXI4_RDATA_WIDTH]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; ARREADY is registered and follows the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ar_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_ready_q <= (state_d == IDLE);
    end
  end

  // Burst context capture and issue-side address/beat counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q     <= '0;
      user_q   <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      addr_q   <= '0;
      issued_q <= '0;
    end else if (ar_hs) begin
      id_q     <= bus.ARID_i;
      user_q   <= bus.ARUSER_i;
      len_q    <= bus.ARLEN_i;
      burst_q  <= bus.ARBURST_i;
      addr_q   <= bus.ARADDR_i[OFFS +: MEM_ADDR_WIDTH];
      issued_q <= '0;
    end else if (mem_acc) begin
      issued_q <= issued_q + 9'd1;
      // FIXED stays put; INCR, WRAP and the reserved code all step one word.
      if (burst_q != 2'b00) addr_q <= addr_q + MEM_ADDR_WIDTH'(1);
    end
  end

  // Track the single read in flight so its data is captured one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= mem_acc;
      inflight_last_q <= (issued_q == {1'b0, len_q});
    end
  end

  axi_read_only_ctrl_fifo #(
    .WIDTH (AXI4_RDATA_WIDTH + 1),
    .DEPTH (2)
  ) u_rbuf (
    .clk      (clk),
    .rst      (rst),
    .push_vld (inflight_q),
    .push_dat ({inflight_last_q, bus.MEM_Q_i}),
    .pop_rdy  (bus.RREADY_i),
    .head_dat (head),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign bus.ARREADY_o = ar_ready_q;
  assign bus.RVALID_o  = ~fifo_empty;
  assign bus.RDATA_o   = head[AXI4_RDATA_WIDTH-1:0];
  assign bus.RLAST_o   = ~fifo_empty & head[AXI4_RDATA_WIDTH];
  assign bus.RID_o     = id_q;
  assign bus.RUSER_o   = user_q;
  assign bus.RRESP_o   = 2'b00;

  assign bus.valid_o   = req_vld;
  assign bus.MEM_CEN_o = ~req_vld;
  assign bus.MEM_WEN_o = 1'b1;
  assign bus.MEM_A_o   = addr_q;
  assign bus.MEM_D_o   = '0;
  assign bus.MEM_BE_o  = '1;
endmodule

// File: tb/tb_axi_read_only_ctrl.sv
// Directed bench for axi_read_only_ctrl with a word*8 memory model.
// Latency and throughput are checked from a posedge monitor's cycle stamps.
// Backpressure cases stall RREADY and randomise grant_i.
module tb_axi_read_only_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_read_only_ctrl_if bus ();

  axi_read_only_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [15:0] id;
    logic [9:0]  user;
    logic [1:0]  resp;
  } beat_t;

  beat_t       beats[$];
  logic [15:0] acc_addr[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_cyc, rv_cyc, lastpop_cyc, rise_cyc;
  int req_cnt = 0;
  int drop_err = 0;
  int hold_err = 0;
  bit seen_rv = 0;
  bit prev_ar = 0;
  bit pv = 0;
  bit prv = 0;
  bit rnd_done = 0;
  logic [15:0] pa;
  logic [63:0] pd;
  logic        pl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory: word i holds i*8, data returned one cycle after an accepted request.
  always @(posedge clk)
    if (bus.valid_o && bus.grant_i) bus.MEM_Q_i <= 64'(bus.MEM_A_o) << 3;

  // Monitor: handshakes, cycle stamps and stability rules.
  always @(posedge clk) begin
    if (rst) begin
      pv = 0; prv = 0; prev_ar = 0;
    end else begin
      if (bus.ARVALID_i && bus.ARREADY_o) begin hs_cyc = cyc; seen_rv = 0; end
      if (bus.RVALID_o && !seen_rv) begin rv_cyc = cyc; seen_rv = 1; end
      if (bus.RVALID_o && bus.RREADY_i) begin
        beats.push_back('{bus.RDATA_o, bus.RLAST_o, bus.RID_o, bus.RUSER_o, bus.RRESP_o});
        if (bus.RLAST_o) lastpop_cyc = cyc;
      end
      if (bus.ARREADY_o && !prev_ar) rise_cyc = cyc;
      prev_ar = bus.ARREADY_o;
      if (bus.valid_o && bus.grant_i) begin req_cnt++; acc_addr.push_back(bus.MEM_A_o); end
      if (pv && (!bus.valid_o || bus.MEM_A_o != pa)) drop_err++;
      pv = bus.valid_o & ~bus.grant_i;
      pa = bus.MEM_A_o;
      if (prv && (!bus.RVALID_o || bus.RDATA_o != pd || bus.RLAST_o != pl)) hold_err++;
      prv = bus.RVALID_o & ~bus.RREADY_i;
      pd = bus.RDATA_o;
      pl = bus.RLAST_o;
    end
    cyc++;
  end

  task automatic do_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                       input logic [15:0] id, input logic [9:0] user);
    for (int i = 0; i < 200 && !bus.ARREADY_o; i++) @(negedge clk);
    chk("arready_wait", 64'(bus.ARREADY_o), 64'd1);
    bus.ARADDR_i  = addr;
    bus.ARLEN_i   = len;
    bus.ARBURST_i = burst;
    bus.ARID_i    = id;
    bus.ARUSER_i  = user;
    bus.ARVALID_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ARVALID_i = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && beats.size() < n; i++) @(negedge clk);
    chk("beat_count", 64'(beats.size()), 64'(n));
  endtask

  task automatic chk_beats(input string tag, input logic [63:0] base, input logic [63:0] step,
                           input int n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      chk({tag, "_data"}, beats[i].data, base + step * 64'(i));
      chk({tag, "_last"}, 64'(beats[i].last), 64'(i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.ARID_i = '0; bus.ARADDR_i = '0; bus.ARLEN_i = '0; bus.ARSIZE_i = 3'd3;
    bus.ARBURST_i = 2'b01; bus.ARLOCK_i = 1'b0; bus.ARCACHE_i = '0; bus.ARPROT_i = '0;
    bus.ARREGION_i = '0; bus.ARUSER_i = '0; bus.ARQOS_i = '0; bus.ARVALID_i = 1'b0;
    bus.RREADY_i = 1'b1; bus.grant_i = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(bus.ARREADY_o), 64'd0);
    chk("rst_rvalid",  64'(bus.RVALID_o),  64'd0);
    chk("rst_cen",     64'(bus.MEM_CEN_o), 64'd1);
    chk("rst_valid",   64'(bus.valid_o),   64'd0);
    chk("rst_addr",    64'(bus.MEM_A_o),   64'd0);
    chk("rst_wen_be",  64'({bus.MEM_WEN_o, bus.MEM_BE_o}), 64'h1FF);
    rst = 1'b0;

    // Single beat, len 0
    do_ar(32'h0, 8'd0, 2'b01, 16'd5, 10'h3);
    wait_beats(1, 50);
    chk_beats("t1", 64'h0, 64'h8, 1);
    chk("t1_rid",   64'(beats[0].id),   64'd5);
    chk("t1_ruser", 64'(beats[0].user), 64'h3);
    chk("t1_rresp", 64'(beats[0].resp), 64'd0);
    repeat (3) @(negedge clk);
    chk("t1_arready_lat", 64'(rise_cyc - lastpop_cyc), 64'd1);

    // INCR len 7, no stalls
    beats.delete();
    do_ar(32'h40, 8'd7, 2'b01, 16'd9, 10'h11);
    wait_beats(8, 100);
    chk_beats("t2", 64'h40, 64'h8, 8);
    chk("t2_first_lat", 64'(rv_cyc - hs_cyc), 64'd3);
    chk("t2_b2b",       64'(lastpop_cyc - rv_cyc), 64'd7);

    // Same burst with RREADY held low for 20 cycles
    beats.delete();
    req_cnt = 0;
    bus.RREADY_i = 1'b0;
    do_ar(32'h40, 8'd7, 2'b01, 16'd9, 10'h11);
    repeat (20) @(negedge clk);
    chk("t3_reqs_stalled", 64'(req_cnt), 64'd2);
    chk("t3_rvalid",       64'(bus.RVALID_o), 64'd1);
    chk("t3_rdata",        bus.RDATA_o, 64'h40);
    bus.RREADY_i = 1'b1;
    wait_beats(8, 100);
    chk_beats("t3", 64'h40, 64'h8, 8);
    chk("t3_reqs_total", 64'(req_cnt), 64'd8);

    // FIXED len 3 with random grant and RREADY
    beats.delete();
    rnd_done = 0;
    fork
      while (!rnd_done) begin
        @(negedge clk);
        bus.grant_i  = 1'($urandom_range(0, 1));
        bus.RREADY_i = 1'($urandom_range(0, 1));
      end
    join_none
    do_ar(32'h80, 8'd3, 2'b00, 16'd7, 10'h2);
    wait_beats(4, 500);
    rnd_done = 1;
    repeat (2) @(negedge clk);
    bus.grant_i = 1'b1;
    bus.RREADY_i = 1'b1;
    chk_beats("t4", 64'h80, 64'h0, 4);
    chk("t4_valid_drop", 64'(drop_err), 64'd0);
    chk("t4_rvalid_hold", 64'(hold_err), 64'd0);

    // INCR across the top of the memory address space
    beats.delete();
    acc_addr.delete();
    do_ar(32'h7FFF0, 8'd3, 2'b01, 16'd1, 10'h0);
    wait_beats(4, 100);
    chk("t5_nreq", 64'(acc_addr.size()), 64'd4);
    if (acc_addr.size() == 4) begin
      chk("t5_a0", 64'(acc_addr[0]), 64'hFFFE);
      chk("t5_a1", 64'(acc_addr[1]), 64'hFFFF);
      chk("t5_a2", 64'(acc_addr[2]), 64'h0000);
      chk("t5_a3", 64'(acc_addr[3]), 64'h0001);
    end
    if (beats.size() == 4) begin
      chk("t5_d1", beats[1].data, 64'h7FFF8);
      chk("t5_d2", beats[2].data, 64'h0);
    end

    // Reset in the middle of a len 7 burst, then a fresh len 1 burst
    beats.delete();
    bus.RREADY_i = 1'b0;
    do_ar(32'h40, 8'd7, 2'b01, 16'd9, 10'h11);
    repeat (4) @(negedge clk);
    bus.RREADY_i = 1'b1;
    wait_beats(3, 50);
    rst = 1'b1;
    #1;
    chk("t6_rvalid", 64'(bus.RVALID_o),  64'd0);
    chk("t6_arready", 64'(bus.ARREADY_o), 64'd0);
    chk("t6_cen",    64'(bus.MEM_CEN_o), 64'd1);
    chk("t6_addr",   64'(bus.MEM_A_o),   64'd0);
    chk("t6_rout",   64'({bus.RDATA_o, bus.RLAST_o}), 64'd0);
    chk("t6_rid",    64'({bus.RID_o, bus.RUSER_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    beats.delete();
    do_ar(32'h100, 8'd1, 2'b01, 16'd3, 10'h5);
    wait_beats(2, 50);
    repeat (10) @(negedge clk);
    chk("t6_no_stale", 64'(beats.size()), 64'd2);
    chk_beats("t6", 64'h100, 64'h8, 2);
    if (beats.size() > 0) chk("t6_rid_new", 64'(beats[0].id), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
